// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: op encodings, FSM states,
// and the counter-width helper.
package alu_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_serial_seq_if.sv
// Request/response bundle between the issue stage, the serial ALU and writeback.
interface alu_serial_seq_if #(parameter int WIDTH = 32);

    // Request: transfers on a rising edge with in_valid & in_ready; in_valid outside IDLE is
    // ignored. Response: result/flags are held stable while out_valid & ~out_ready, and are
    // consumed on a rising edge with out_valid & out_ready.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             Ainvert;
    logic             Binvert;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             c_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, Ainvert, Binvert, op, out_ready,
        input  in_ready, out_valid, result, zero, c_out, overflow
    );

    modport slave (
        input  in_valid, a, b, Ainvert, Binvert, op, out_ready,
        output in_ready, out_valid, result, zero, c_out, overflow
    );

endinterface

// File: rtl/alu_serial_bit.sv
// Combinational one-bit ALU slice: operand inversion, full adder, op select.
module alu_serial_bit
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       ainvert,
    input  logic       binvert,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       res,
    output logic       cout
);

    logic ai;
    logic bi;
    logic sum;

    assign ai   = a ^ ainvert;
    assign bi   = b ^ binvert;
    assign sum  = ai ^ bi ^ cin;
    assign cout = (ai & bi) | (cin & (ai ^ bi));

    // SLT passes the sum through; the sequencer reduces it to the less bit at the end.
    always_comb begin
        res = sum;
        case (op)
            OP_AND:  res = ai & bi;
            OP_OR:   res = ai | bi;
            default: res = sum;
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: one result bit per clock, LSB first, through alu_serial_bit.
// Define ALU_SLT_OVF_FIX_EN to make SLT a correct signed compare under subtraction overflow.
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    alu_serial_seq_if.slave  bus,
    output alu_state_e       dbg_state
);

    localparam int            CW   = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    alu_state_e       state;
    alu_state_e       state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             ainv_q;
    logic             binv_q;
    logic [1:0]       op_q;
    logic             carry;
    logic             c_msb_in;
    logic [CW-1:0]    bit_cnt;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             c_out_q;
    logic             overflow_q;

    logic             accept;
    logic             finalize;
    logic             slice_res;
    logic             slice_cout;
    logic             less;
    logic [WIDTH-1:0] final_result;

    assign accept   = bus.in_valid && (state == ST_IDLE);
    assign finalize = (state == ST_DONE) && !out_valid_q;

    alu_serial_bit u_bit (
        .a       (a_sr[0]),
        .b       (b_sr[0]),
        .ainvert (ainv_q),
        .binvert (binv_q),
        .cin     (carry),
        .op      (op_q),
        .res     (slice_res),
        .cout    (slice_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.in_valid)                  state_nxt = ST_RUN;
            ST_RUN:  if (bit_cnt == LAST)               state_nxt = ST_DONE;
            ST_DONE: if (out_valid_q && bus.out_ready)  state_nxt = ST_IDLE;
            default:                                    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            ainv_q   <= 1'b0;
            binv_q   <= 1'b0;
            op_q     <= OP_AND;
            carry    <= 1'b0;
            c_msb_in <= 1'b0;
            bit_cnt  <= '0;
        end else if (accept) begin
            a_sr    <= bus.a;
            b_sr    <= bus.b;
            ainv_q  <= bus.Ainvert;
            binv_q  <= bus.Binvert;
            op_q    <= bus.op;
            carry   <= bus.Binvert & ~bus.Ainvert;
            bit_cnt <= '0;
        end else if (state == ST_RUN) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            res_sr  <= {slice_res, res_sr[WIDTH-1:1]};
            carry   <= slice_cout;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST) c_msb_in <= carry;
        end
    end

    // After the last shift, carry holds the MSB carry-out and res_sr[MSB] the sum sign.
`ifdef ALU_SLT_OVF_FIX_EN
    assign less = res_sr[WIDTH-1] ^ (c_msb_in ^ carry);
`else
    assign less = res_sr[WIDTH-1];
`endif

    assign final_result = (op_q == OP_SLT) ? WIDTH'(less) : res_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            c_out_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (finalize) begin
            out_valid_q <= 1'b1;
            result_q    <= final_result;
            zero_q      <= (final_result == '0);
            c_out_q     <= carry;
            overflow_q  <= c_msb_in ^ carry;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.c_out     = c_out_q;
    assign bus.overflow  = overflow_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Randomized self-checking bench for alu_serial_seq against an arithmetic reference model.
module tb_alu_serial_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    alu_state_e dbg_state;

    alu_serial_seq_if #(.WIDTH(W)) bus ();

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Packed as {overflow, c_out, zero, result}.
    logic [W+2:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [W+2:0] model(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                                           input logic ai, input logic bi, input logic [1:0] op_v);
        logic [W-1:0] x, y, sum, res;
        logic [W:0]   full;
        logic         cin, ovf, less;
        x    = ai ? ~a_v : a_v;
        y    = bi ? ~b_v : b_v;
        cin  = bi & ~ai;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
        sum  = full[W-1:0];
        ovf  = (x[W-1] == y[W-1]) && (sum[W-1] != x[W-1]);
`ifdef ALU_SLT_OVF_FIX_EN
        less = sum[W-1] ^ ovf;
`else
        less = sum[W-1];
`endif
        case (op_v)
            2'b00:   res = x & y;
            2'b01:   res = x | y;
            2'b10:   res = sum;
            default: res = {{(W-1){1'b0}}, less};
        endcase
        return {ovf, full[W], (res == '0), res};
    endfunction

    // Called #1 after a rising edge with the DUT expected idle.
    task automatic do_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                         input logic ai, input logic bi, input logic [1:0] op_v, input int hold);
        logic [W+2:0] e;
        int lat;
        check("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.a        = a_v;
        bus.b        = b_v;
        bus.Ainvert  = ai;
        bus.Binvert  = bi;
        bus.op       = op_v;
        exp_q.push_back(model(a_v, b_v, ai, bi, op_v));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 4 * W) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, W + 1);
        e = exp_q.pop_front();
        check("result",   bus.result,   e[W-1:0]);
        check("zero",     bus.zero,     e[W]);
        check("c_out",    bus.c_out,    e[W+1]);
        check("overflow", bus.overflow, e[W+2]);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = $urandom;
            bus.op       = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
            check("hold_valid",  bus.out_valid, 1);
            check("hold_ready",  bus.in_ready,  0);
            check("hold_result", {bus.overflow, bus.c_out, bus.zero, bus.result}, e);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("drain_valid", bus.out_valid, 0);
        check("drain_ready", bus.in_ready,  1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  bus.in_ready,  1);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_result"},    bus.result,    0);
        check({tag, "_zero"},      bus.zero,      1);
        check({tag, "_c_out"},     bus.c_out,     0);
        check({tag, "_overflow"},  bus.overflow,  0);
        check({tag, "_state"},     dbg_state,     ST_IDLE);
    endtask

    task automatic reset_mid_run();
        bus.in_valid = 1'b1;
        bus.a        = 32'hFFFF_FFFF;
        bus.b        = 32'h0000_0001;
        bus.Ainvert  = 1'b0;
        bus.Binvert  = 1'b0;
        bus.op       = OP_ADD;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("mid_run_state", dbg_state, ST_RUN);
        #2 rst = 1'b1;
        #1 check_reset_values("mid_rst");
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready", bus.in_ready,  1);
        check("post_rst_valid", bus.out_valid, 0);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.Ainvert   = 1'b0;
        bus.Binvert   = 1'b0;
        bus.op        = OP_AND;
        bus.out_ready = 1'b0;
        #12;
        check_reset_values("reset");
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        do_op(32'd7, 32'd5, 1'b0, 1'b0, OP_ADD, 0);
        do_op(32'd5, 32'd7, 1'b0, 1'b1, OP_ADD, 0);
        do_op(32'd7, 32'd7, 1'b0, 1'b1, OP_ADD, 0);
        do_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, OP_ADD, 0);
        do_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, OP_SLT, 0);
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, OP_SLT, 0);
        do_op(32'h0F0F_0F0F, 32'h00FF_00FF, 1'b1, 1'b1, OP_AND, 10);

        reset_mid_run();
        do_op(32'd123, 32'd456, 1'b0, 1'b0, OP_ADD, 1);

        for (int n = 0; n < 40; n++) begin
            do_op(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
